conv_bram_1d_img_loader: RTL and testbench

//  Upstream feeder for the 1-D BRAM convolution engine. Accepts one image (IMG_W beats of IMG_D channels)
//  on a val/rdy stream and writes it into the IMG_D per-channel image RAMs. Captures the filter bank, then

---
 rtl/conv_1d_pkg.sv | 27 ++
 rtl/conv_bram_1d_img_loader.sv | 145 ++++++++++++++
 tb/tb_conv_bram_1d_img_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_1d_pkg.sv
// Shared types and default geometry for the 1-D BRAM convolution datapath.
package conv_1d_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_IMG_W      = 32;
    localparam int unsigned DEF_IMG_D      = 4;
    localparam int unsigned DEF_FILTER_L   = 3;
    localparam int unsigned DEF_RESULT_D   = 4;

    localparam int unsigned FILTER_K           = DEF_RESULT_D;
    localparam int unsigned IMG_RAM_ADDR_WIDTH = $clog2(DEF_IMG_W);
    localparam int unsigned FIL_W              = DEF_DATA_WIDTH * FILTER_K * DEF_IMG_D * DEF_FILTER_L;

    // Filter bank width for an arbitrary geometry.
    function automatic int unsigned fil_bank_width(input int unsigned dw, input int unsigned k,
                                                   input int unsigned d, input int unsigned l);
        return dw * k * d * l;
    endfunction

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/conv_bram_1d_img_loader.sv
// Streams one image into the per-channel image RAMs, latches the filter bank and
// starts the convolution engine; the RAMs and filter stay frozen until the engine idles.
module conv_bram_1d_img_loader
    import conv_1d_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_D      = DEF_IMG_D,
    parameter int unsigned FILTER_L   = DEF_FILTER_L,
    parameter int unsigned RESULT_D   = DEF_RESULT_D,
    localparam int unsigned ADDR_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int unsigned PIX_W      = DATA_WIDTH * IMG_D,
    localparam int unsigned FIL_BANK_W = fil_bank_width(DATA_WIDTH, RESULT_D, IMG_D, FILTER_L)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PIX_W-1:0]          pix_data,
    input  logic                      pix_val,
    output logic                      pix_rdy,
    input  logic [FIL_BANK_W-1:0]     fil_in,
    input  logic                      fil_val,
    output logic                      fil_rdy,
    output logic [ADDR_W*IMG_D-1:0]   img_wraddr,
    output logic [PIX_W-1:0]          img_wrdata,
    output logic [IMG_D-1:0]          img_wren,
    output logic [FIL_BANK_W-1:0]     fil,
    output logic                      conv_val,
    input  logic                      conv_rdy,
    output logic                      busy
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W - 1);

    loader_state_e           state, state_nx;
    logic [ADDR_W-1:0]       pix_cnt, pix_cnt_nx;
    logic                    fil_have, fil_have_nx;
    logic                    img_full, img_full_nx;
    logic                    wr_pend, wr_pend_nx;
    logic [ADDR_W-1:0]       wr_addr, wr_addr_nx;
    logic [PIX_W-1:0]        wr_data, wr_data_nx;
    logic [FIL_BANK_W-1:0]   fil_q, fil_nx;
    logic                    conv_val_nx;
    logic                    busy_nx;
    logic                    beat_acc;
    logic                    fil_acc;

    assign pix_rdy  = (state == LOAD) && !img_full;
    assign fil_rdy  = (state == LOAD) && !fil_have;
    assign beat_acc = pix_val && pix_rdy;
    assign fil_acc  = fil_val && fil_rdy;

    // Next-state and next-register logic.
    always_comb begin
        state_nx    = state;
        pix_cnt_nx  = pix_cnt;
        fil_have_nx = fil_have;
        img_full_nx = img_full;
        wr_pend_nx  = 1'b0;
        wr_addr_nx  = wr_addr;
        wr_data_nx  = wr_data;
        fil_nx      = fil_q;

        case (state)
            LOAD: begin
                if (beat_acc) begin
                    wr_pend_nx = 1'b1;
                    wr_addr_nx = pix_cnt;
                    wr_data_nx = pix_data;
                    if (pix_cnt == LAST_PIX) begin
                        pix_cnt_nx  = '0;
                        img_full_nx = 1'b1;
                    end else begin
                        pix_cnt_nx = pix_cnt + ADDR_W'(1);
                    end
                end
                if (fil_acc) begin
                    fil_nx      = fil_in;
                    fil_have_nx = 1'b1;
                end
                // The final RAM write lands on the same edge that raises conv_val.
                if (img_full && fil_have && !beat_acc) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (conv_rdy) begin
                    state_nx = GUARD;
                end
            end
            GUARD: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (conv_rdy) begin
                    state_nx    = LOAD;
                    img_full_nx = 1'b0;
                    fil_have_nx = 1'b0;
                    pix_cnt_nx  = '0;
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase

        conv_val_nx = (state_nx == ISSUE);
        busy_nx     = (state_nx != LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= LOAD;
            pix_cnt  <= '0;
            fil_have <= 1'b0;
            img_full <= 1'b0;
            wr_pend  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            fil_q    <= '0;
            conv_val <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            pix_cnt  <= pix_cnt_nx;
            fil_have <= fil_have_nx;
            img_full <= img_full_nx;
            wr_pend  <= wr_pend_nx;
            wr_addr  <= wr_addr_nx;
            wr_data  <= wr_data_nx;
            fil_q    <= fil_nx;
            conv_val <= conv_val_nx;
            busy     <= busy_nx;
        end
    end

    // Every channel RAM sees the same address and enable.
    for (genvar g = 0; g < IMG_D; g++) begin : g_ram_fanout
        assign img_wraddr[g*ADDR_W +: ADDR_W] = wr_addr;
        assign img_wren[g]                    = wr_pend;
    end

    assign img_wrdata = wr_data;
    assign fil        = fil_q;

endmodule

// File: tb/tb_conv_bram_1d_img_loader.sv
// Randomized bench for the image loader against a phase-level reference model.
module tb_conv_bram_1d_img_loader;
    import conv_1d_pkg::*;

    localparam int unsigned DW   = DEF_DATA_WIDTH;
    localparam int unsigned NPIX = DEF_IMG_W;
    localparam int unsigned ND   = DEF_IMG_D;
    localparam int unsigned AW   = IMG_RAM_ADDR_WIDTH;
    localparam int unsigned FW   = FIL_W;
    localparam int unsigned PW   = DW * ND;

    localparam int PH_LOAD  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_GUARD = 2;
    localparam int PH_WAIT  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [PW-1:0]     pix_data;
    logic              pix_val;
    logic              pix_rdy;
    logic [FW-1:0]     fil_in;
    logic              fil_val;
    logic              fil_rdy;
    logic [AW*ND-1:0]  img_wraddr;
    logic [PW-1:0]     img_wrdata;
    logic [ND-1:0]     img_wren;
    logic [FW-1:0]     fil;
    logic              conv_val;
    logic              conv_rdy;
    logic              busy;

    always #5 clk = ~clk;

    conv_bram_1d_img_loader #(
        .DATA_WIDTH (DW),
        .IMG_W      (NPIX),
        .IMG_D      (ND),
        .FILTER_L   (DEF_FILTER_L),
        .RESULT_D   (DEF_RESULT_D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_data   (pix_data),
        .pix_val    (pix_val),
        .pix_rdy    (pix_rdy),
        .fil_in     (fil_in),
        .fil_val    (fil_val),
        .fil_rdy    (fil_rdy),
        .img_wraddr (img_wraddr),
        .img_wrdata (img_wrdata),
        .img_wren   (img_wren),
        .fil        (fil),
        .conv_val   (conv_val),
        .conv_rdy   (conv_rdy),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: handshake phase, beats taken this image, filter held, expected write.
    int            m_ph;
    int            m_beats;
    bit            m_fil_have;
    logic [FW-1:0] m_fil;
    bit            m_wr_v;
    logic [AW-1:0] m_wr_addr;
    logic [PW-1:0] m_wr_data;
    bit            m_acc;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph       = PH_LOAD;
        m_beats    = 0;
        m_fil_have = 1'b0;
        m_fil      = '0;
        m_wr_v     = 1'b0;
        m_wr_addr  = '0;
        m_wr_data  = '0;
        m_acc      = 1'b0;
    endtask

    task automatic check_outputs();
        logic [ND-1:0] exp_en;
        exp_en = m_wr_v ? '1 : '0;
        check("pix_rdy",  pix_rdy,  (m_ph == PH_LOAD) && (m_beats < NPIX));
        check("fil_rdy",  fil_rdy,  (m_ph == PH_LOAD) && !m_fil_have);
        check("conv_val", conv_val, m_ph == PH_ISSUE);
        check("busy",     busy,     m_ph != PH_LOAD);
        check("fil",      fil,      m_fil);
        check("img_wren", img_wren, exp_en);
        if (m_wr_v) begin
            for (int d = 0; d < ND; d++)
                check("img_wraddr", img_wraddr[d*AW +: AW], m_wr_addr);
            check("img_wrdata", img_wrdata, m_wr_data);
        end
    endtask

    // Apply this cycle's inputs to the model; the effect is visible next cycle.
    task automatic model_step();
        int nph;
        bit nwr;
        nph   = m_ph;
        nwr   = 1'b0;
        m_acc = 1'b0;
        case (m_ph)
            PH_LOAD: begin
                if (m_beats == NPIX && m_fil_have) nph = PH_ISSUE;
                if (pix_val && m_beats < NPIX) begin
                    nwr       = 1'b1;
                    m_wr_addr = AW'(m_beats);
                    m_wr_data = pix_data;
                    m_beats++;
                    m_acc = 1'b1;
                end
                if (fil_val && !m_fil_have) begin
                    m_fil      = fil_in;
                    m_fil_have = 1'b1;
                end
            end
            PH_ISSUE: if (conv_rdy) nph = PH_GUARD;
            PH_GUARD: nph = PH_WAIT;
            PH_WAIT: begin
                if (conv_rdy) begin
                    nph        = PH_LOAD;
                    m_beats    = 0;
                    m_fil_have = 1'b0;
                end
            end
            default: ;
        endcase
        m_ph   = nph;
        m_wr_v = nwr;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (reset) model_step();
        else       model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] rand_fil();
        logic [FW-1:0] r;
        for (int i = 0; i < FW; i++) r[i] = 1'($urandom_range(1));
        return r;
    endfunction

    task automatic send_fil();
        fil_in  = rand_fil();
        fil_val = 1'b1;
        tick();
        fil_val = 1'b0;
    endtask

    // Stream n beats (beat k = k on every channel) with random gaps; optionally offer the filter from beat fil_at.
    task automatic send_beats(input int n, input int gap_pct, input int fil_at);
        int k;
        int budget;
        logic [DW-1:0] b;
        k = 0;
        budget = 0;
        while (k < n && budget < 2000) begin
            b        = DW'(k);
            pix_val  = ($urandom_range(99) >= gap_pct);
            pix_data = {ND{b}};
            conv_rdy = 1'($urandom_range(1));
            if (fil_at >= 0 && k >= fil_at && !m_fil_have) begin
                if (!fil_val) fil_in = rand_fil();
                fil_val = 1'b1;
            end else begin
                fil_val = 1'b0;
            end
            tick();
            if (m_acc) k++;
            budget++;
        end
        pix_val  = 1'b0;
        fil_val  = 1'b0;
        conv_rdy = 1'b0;
        if (budget >= 2000) check("beat_budget", FW'(k), FW'(n));
    endtask

    // Engine handshake: stall 5 cycles, accept, re-raise during GUARD, low phase, then release.
    task automatic handshake(input bit hold_pix);
        int n;
        n = 0;
        while (m_ph != PH_ISSUE && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("issue_timeout", FW'(m_ph), FW'(PH_ISSUE));
        pix_val  = hold_pix;
        pix_data = PW'($urandom);
        conv_rdy = 1'b0;
        repeat (5) tick();
        conv_rdy = 1'b1;
        tick();
        tick();
        conv_rdy = 1'b0;
        repeat (3) tick();
        conv_rdy = 1'b1;
        tick();
        conv_rdy = 1'b0;
        pix_val  = 1'b0;
        tick();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_wren",     img_wren,   '0);
        check("rst_wraddr",   img_wraddr, '0);
        check("rst_wrdata",   img_wrdata, '0);
        check("rst_fil",      fil,        '0);
        check("rst_conv_val", conv_val,   '0);
        check("rst_busy",     busy,       '0);
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        pix_data = '0;
        pix_val  = 1'b0;
        fil_in   = '0;
        fil_val  = 1'b0;
        conv_rdy = 1'b0;
        model_reset();

        // Idle under reset.
        repeat (3) tick();
        check("idle_wraddr", img_wraddr, '0);
        check("idle_wrdata", img_wrdata, '0);
        reset = 1'b1;
        tick();

        // Filter first, then a back-to-back image.
        send_fil();
        send_beats(NPIX, 0, -1);
        handshake(1'b0);

        // Gapped image, filter arriving well after the last beat.
        send_beats(NPIX, 40, -1);
        repeat (10) tick();
        send_fil();
        handshake(1'b0);

        // Reset part-way through an image; the next image restarts at address 0.
        send_fil();
        send_beats(17, 20, -1);
        do_reset(2);
        send_beats(NPIX, 25, -1);
        send_fil();
        handshake(1'b0);

        // Back-to-back images with the next image pushing during the engine run.
        send_beats(NPIX, 0, 5);
        handshake(1'b1);
        send_beats(NPIX, 10, 31);
        handshake(1'b1);

        // Randomized filter placement and gaps.
        for (int it = 0; it < 4; it++) begin
            send_beats(NPIX, int'($urandom_range(50)), int'($urandom_range(NPIX + 2)));
            if (!m_fil_have) send_fil();
            handshake(1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
